// File: rtl/ixc_ev_pkg.sv
`default_nettype none
// ============================================================================
// Module : ixc_ev_pkg
// Brief  : Shared types and constants for the central event scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package ixc_ev_pkg;

   // Scheduler sequencing states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      SETTLE = 2'd2,
      BWAIT  = 2'd3
   } ev_state_t;

   // Status vectors are zero-extended to this width before reduction,
   // so a scheduler may have at most this many reporting generators.
   localparam int c_SRC_W_MAX = 32;
   localparam logic [c_SRC_W_MAX-1:0] c_SRC_NONE = '0;

   // Default timing for a scheduler instance.
   localparam int c_DEF_SETTLE_CYC = 2;
   localparam int c_DEF_MAX_WAIT   = 255;

   // True when any generator reports the flag in question.
   function automatic logic anySet(input logic [c_SRC_W_MAX-1:0] v);
      return (v != c_SRC_NONE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ixc_ev_wdog.sv
`default_nettype none
// ============================================================================
// Module : ixc_ev_wdog
// Brief  : Loadable up-counter with terminal flag, used as a phase watchdog.
//          o_term is high while the count sits on its LIMIT-th cycle
//          (count == LIMIT-1), so a phase that started at 0 times out after
//          exactly LIMIT counted cycles.
// Rev    : 1.0  initial release
// ============================================================================
module ixc_ev_wdog #(
   parameter int WIDTH = 8,
   parameter int LIMIT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadVal,
   input  logic             i_en,
   output logic             o_term
);

   logic [WIDTH-1:0] r_count;

   // Load has priority over counting so a phase restart is always clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_en) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_term = (r_count == WIDTH'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/ixc_ev_sched.sv
`default_nettype none
// ============================================================================
// Module : ixc_ev_sched
// Brief  : Central event scheduler. Opens the global event window, waits for
//          all clock generators to settle, holds clocks during bus waits and
//          sequences a host-requested burst of evaluation steps.
// Rev    : 1.0  initial release
// ============================================================================
module ixc_ev_sched
   import ixc_ev_pkg::*;
#(
   parameter int N_SRC      = 4,
   parameter int STEP_W     = 8,
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = c_DEF_SETTLE_CYC,
   parameter int MAX_WAIT   = c_DEF_MAX_WAIT
) (
   input  logic              xclk,
   input  logic              rst,
   input  logic              step_req,
   input  logic [STEP_W-1:0] step_num,
   input  logic              stop_req,
   input  logic              hold,
   input  logic              clr_err,
   input  logic [N_SRC-1:0]  src_active,
   input  logic [N_SRC-1:0]  src_busy,
   input  logic [N_SRC-1:0]  src_bwon,
   input  logic              bp_wait,
   output logic              event_on,
   output logic              b_clk_hold,
   output logic              running,
   output logic              done,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  ev_count
);

   localparam int QW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int WD_W = $clog2(MAX_WAIT + 1);

   ev_state_t         r_state;
   ev_state_t         w_nxtState;
   logic [QW-1:0]     r_quietCnt;
   logic [QW-1:0]     w_quietNxt;
   logic [STEP_W-1:0] r_stepLeft;
   logic [STEP_W-1:0] w_stepLoad;
   logic [CNT_W-1:0]  r_evCount;
   logic              r_eventOn;
   logic              r_bClkHold;
   logic              r_running;
   logic              r_done;
   logic              r_errTimeout;

   logic w_quiet;
   logic w_bw;
   logic w_stepStart;
   logic w_stepEnd;
   logic w_lastStep;
   logic w_timeout;
   logic w_done;
   logic w_wdLoad;
   logic w_wdEn;
   logic w_wdTerm;

   assign w_quiet     = ~anySet(c_SRC_W_MAX'(src_active)) & ~anySet(c_SRC_W_MAX'(src_busy));
   assign w_bw        = anySet(c_SRC_W_MAX'(src_bwon)) | bp_wait;
   assign w_stepLoad  = (step_num == '0) ? STEP_W'(1) : step_num;
   assign w_stepStart = (r_state == IDLE) & step_req & ~hold;
   assign w_lastStep  = (r_stepLeft == STEP_W'(1));

   // Watchdog spans SETTLE and BWAIT; it restarts only when an event opens.
   ixc_ev_wdog #(
      .WIDTH (WD_W),
      .LIMIT (MAX_WAIT)
   ) u_wdog (
      .clk       (xclk),
      .rst       (rst),
      .i_load    (w_wdLoad),
      .i_loadVal ('0),
      .i_en      (w_wdEn),
      .o_term    (w_wdTerm)
   );

   // Next-state logic; step completion outranks a coincident timeout.
   always_comb begin
      w_nxtState = r_state;
      w_quietNxt = r_quietCnt;
      w_stepEnd  = 1'b0;
      w_timeout  = 1'b0;
      w_wdLoad   = 1'b0;
      w_wdEn     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_stepStart) begin
               w_nxtState = EVAL;
            end
         end
         EVAL: begin
            w_nxtState = SETTLE;
            w_quietNxt = '0;
            w_wdLoad   = 1'b1;
         end
         SETTLE: begin
            w_wdEn     = 1'b1;
            w_quietNxt = w_quiet ? (r_quietCnt + QW'(1)) : '0;
            if (w_quiet && (r_quietCnt == QW'(SETTLE_CYC - 1))) begin
               if (w_bw) begin
                  w_nxtState = BWAIT;
               end else begin
                  w_stepEnd = 1'b1;
               end
            end else if (w_wdTerm) begin
               w_timeout = 1'b1;
            end
         end
         BWAIT: begin
            w_wdEn = 1'b1;
            if (!w_bw) begin
               w_stepEnd = 1'b1;
            end else if (w_wdTerm) begin
               w_timeout = 1'b1;
            end
         end
         default: w_nxtState = IDLE;
      endcase
      if (w_stepEnd) begin
         w_nxtState = (w_lastStep | stop_req) ? IDLE : EVAL;
      end
      if (w_timeout) begin
         w_nxtState = IDLE;
      end
   end

   assign w_done = (w_stepEnd & (w_lastStep | stop_req)) | w_timeout;

   // State, settle counter and remaining-step bookkeeping.
   always_ff @(posedge xclk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_quietCnt <= '0;
         r_stepLeft <= '0;
      end else begin
         r_state    <= w_nxtState;
         r_quietCnt <= w_quietNxt;
         if (w_stepStart) begin
            r_stepLeft <= w_stepLoad;
         end else if (w_stepEnd) begin
            r_stepLeft <= r_stepLeft - STEP_W'(1);
         end
      end
   end

   // Registered outputs follow the next state so they align with it.
   always_ff @(posedge xclk or posedge rst) begin
      if (rst) begin
         r_eventOn    <= 1'b0;
         r_bClkHold   <= 1'b0;
         r_running    <= 1'b0;
         r_done       <= 1'b0;
         r_errTimeout <= 1'b0;
         r_evCount    <= '0;
      end else begin
         r_eventOn  <= (w_nxtState == EVAL);
         r_bClkHold <= (w_nxtState == BWAIT);
         r_running  <= (w_nxtState != IDLE);
         r_done     <= w_done;
         if (w_timeout) begin
            r_errTimeout <= 1'b1;
         end else if (clr_err) begin
            r_errTimeout <= 1'b0;
         end
         if (w_stepEnd) begin
            r_evCount <= r_evCount + CNT_W'(1);
         end
      end
   end

   assign event_on    = r_eventOn;
   assign b_clk_hold  = r_bClkHold;
   assign running     = r_running;
   assign done        = r_done;
   assign err_timeout = r_errTimeout;
   assign ev_count    = r_evCount;

endmodule
`default_nettype wire
